// File: rtl/remote_cmd_link_pkg.sv
// Shared definitions for the host-side Knight robot command link.
// Holds the response/opcode constants, the FSM state types and the UART framing helper.
package remote_cmd_link_pkg;

    localparam logic [7:0]  ACK      = 8'hA5;
    localparam logic [15:0] CAL_GYRO = 16'h2000;

    typedef enum logic [1:0] {
        SND_IDLE = 2'd0,
        SND_HI   = 2'd1,
        SND_LO   = 2'd2
    } snd_state_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_e;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_BUSY = 1'b1
    } rx_state_e;

    // 8N1 frame, transmitted from bit 0: start(0), data LSB first, stop(1)
    function automatic logic [9:0] uart_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/remote_cmd_link_uart_xcvr.sv
// Full-duplex 8N1 byte transceiver sharing one BAUD_DIV setting for both directions.
// tx_done/rdy/rx_start are single-cycle strobes derived from registered state only.
module uart_xcvr
    import remote_cmd_link_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_done,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       rx_start
);

    localparam int            CW         = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_TC    = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_HALF  = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] BAUD_ZERO  = CW'(0);
    localparam logic [CW-1:0] BAUD_ONE   = CW'(1);
    localparam logic [3:0]    LAST_BIT   = 4'd9;

    tx_state_e      tx_state_q, tx_state_d;
    logic [CW-1:0]  tx_baud_q,  tx_baud_d;
    logic [3:0]     tx_bit_q,   tx_bit_d;
    logic [8:0]     tx_shift_q, tx_shift_d;
    logic           tx_q,       tx_d;
    logic           tx_tc_s;
    logic           tx_last_s;
    logic           tx_load_s;
    logic [9:0]     tx_frame_s;

    rx_state_e      rx_state_q, rx_state_d;
    logic [CW-1:0]  rx_baud_q,  rx_baud_d;
    logic [3:0]     rx_bit_q,   rx_bit_d;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic           rx_meta_q,  rx_meta_d;
    logic           rx_sync_q,  rx_sync_d;
    logic           rx_prev_q,  rx_prev_d;
    logic           rx_tc_s;
    logic           rx_start_s;
    logic           rx_done_s;

    // Strobes kept as continuous assigns so the top's send FSM can close the
    // back-to-back reload path without a combinational feedback through a process.
    assign tx_tc_s    = (tx_baud_q == BAUD_TC);
    assign tx_last_s  = (tx_state_q == TX_BUSY) && tx_tc_s && (tx_bit_q == LAST_BIT);
    assign tx_load_s  = trmt && ((tx_state_q == TX_IDLE) || tx_last_s);
    assign tx_frame_s = uart_frame(tx_data);

    assign rx_tc_s    = (rx_baud_q == BAUD_TC);
    assign rx_start_s = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;
    assign rx_done_s  = (rx_state_q == RX_BUSY) && rx_tc_s && (rx_bit_q == LAST_BIT);

    assign tx       = tx_q;
    assign tx_done  = tx_last_s;
    assign rx_data  = rx_shift_q;
    assign rdy      = rx_done_s;
    assign rx_start = rx_start_s;

    // Transmit path: load a frame (also straight out of a finishing stop bit), then shift per baud period
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        if (tx_load_s) begin
            tx_state_d = TX_BUSY;
            tx_baud_d  = BAUD_ZERO;
            tx_bit_d   = 4'd0;
            tx_d       = tx_frame_s[0];
            tx_shift_d = tx_frame_s[9:1];
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_baud_d = BAUD_ZERO;
                    tx_bit_d  = 4'd0;
                    tx_d      = 1'b1;
                end
                TX_BUSY: begin
                    if (tx_tc_s) begin
                        tx_baud_d = BAUD_ZERO;
                        if (tx_bit_q == LAST_BIT) begin
                            tx_state_d = TX_IDLE;
                            tx_bit_d   = 4'd0;
                            tx_d       = 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit_q + 4'd1;
                            tx_d       = tx_shift_q[0];
                            tx_shift_d = {1'b1, tx_shift_q[8:1]};
                        end
                    end else begin
                        tx_baud_d = tx_baud_q + BAUD_ONE;
                    end
                end
                default: begin
                    tx_state_d = TX_IDLE;
                    tx_baud_d  = BAUD_ZERO;
                    tx_bit_d   = 4'd0;
                    tx_d       = 1'b1;
                end
            endcase
        end
    end

    // Receive path: double-flop RX, then sample mid-bit starting half a period after the start edge
    always_comb begin
        rx_meta_d  = rx;
        rx_sync_d  = rx_meta_q;
        rx_prev_d  = rx_sync_q;
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_start_s) begin
                    rx_state_d = RX_BUSY;
                    rx_baud_d  = BAUD_HALF;
                    rx_bit_d   = 4'd0;
                end else begin
                    rx_baud_d  = BAUD_ZERO;
                    rx_bit_d   = 4'd0;
                end
            end
            RX_BUSY: begin
                if (rx_tc_s) begin
                    rx_baud_d = BAUD_ZERO;
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = RX_IDLE;
                        rx_bit_d   = 4'd0;
                    end else if (rx_bit_q == 4'd0) begin
                        rx_bit_d   = 4'd1;
                    end else begin
                        rx_bit_d   = rx_bit_q + 4'd1;
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    end
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_ONE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_baud_d  = BAUD_ZERO;
                rx_bit_d   = 4'd0;
            end
        endcase
    end

    // State registers for both directions; synchronizer resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= BAUD_ZERO;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= 9'h1FF;
            tx_q       <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= BAUD_ZERO;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= 8'h00;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
        end
    end

endmodule

// File: rtl/remote_cmd_link.sv
// Host-side remote-control link: sends a 16-bit command as two back-to-back UART bytes
// (high byte first) and captures the robot's single response byte.
module remote_cmd_link
    import remote_cmd_link_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    snd_state_e  snd_state_q, snd_state_d;
    logic [7:0]  lo_byte_q,   lo_byte_d;
    logic        cmd_snt_q,   cmd_snt_d;
    logic        resp_rdy_q,  resp_rdy_d;
    logic [7:0]  resp_q,      resp_d;

    logic        trmt_s;
    logic [7:0]  tx_data_s;
    logic        accept_s;
    logic        tx_done_s;
    logic        rx_rdy_s;
    logic        rx_start_s;
    logic [7:0]  rx_data_s;

    uart_xcvr #(
        .BAUD_DIV (BAUD_DIV)
    ) u_xcvr (
        .clk      (clk),
        .rst      (rst),
        .trmt     (trmt_s),
        .tx_data  (tx_data_s),
        .tx       (TX),
        .tx_done  (tx_done_s),
        .rx       (RX),
        .rx_data  (rx_data_s),
        .rdy      (rx_rdy_s),
        .rx_start (rx_start_s)
    );

    // Two-byte send sequencer; the low byte is reloaded on the high byte's done strobe so no idle gap appears
    always_comb begin
        snd_state_d = snd_state_q;
        lo_byte_d   = lo_byte_q;
        cmd_snt_d   = cmd_snt_q;
        trmt_s      = 1'b0;
        tx_data_s   = lo_byte_q;
        accept_s    = 1'b0;
        case (snd_state_q)
            SND_IDLE: begin
                if (snd_cmd) begin
                    accept_s    = 1'b1;
                    trmt_s      = 1'b1;
                    tx_data_s   = cmd[15:8];
                    lo_byte_d   = cmd[7:0];
                    cmd_snt_d   = 1'b0;
                    snd_state_d = SND_HI;
                end else begin
                    snd_state_d = SND_IDLE;
                end
            end
            SND_HI: begin
                if (tx_done_s) begin
                    trmt_s      = 1'b1;
                    tx_data_s   = lo_byte_q;
                    snd_state_d = SND_LO;
                end else begin
                    snd_state_d = SND_HI;
                end
            end
            SND_LO: begin
                if (tx_done_s) begin
                    cmd_snt_d   = 1'b1;
                    snd_state_d = SND_IDLE;
                end else begin
                    snd_state_d = SND_LO;
                end
            end
            default: begin
                snd_state_d = SND_IDLE;
            end
        endcase
    end

    // Response flag: a completed byte sets it and takes priority over any same-cycle clear
    always_comb begin
        resp_rdy_d = resp_rdy_q;
        resp_d     = resp_q;
        if (rx_rdy_s) begin
            resp_rdy_d = 1'b1;
            resp_d     = rx_data_s;
        end else if (accept_s || rx_start_s) begin
            resp_rdy_d = 1'b0;
        end else begin
            resp_rdy_d = resp_rdy_q;
        end
    end

    // Sequencer and host-visible status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            snd_state_q <= SND_IDLE;
            lo_byte_q   <= 8'h00;
            cmd_snt_q   <= 1'b0;
            resp_rdy_q  <= 1'b0;
            resp_q      <= 8'h00;
        end else begin
            snd_state_q <= snd_state_d;
            lo_byte_q   <= lo_byte_d;
            cmd_snt_q   <= cmd_snt_d;
            resp_rdy_q  <= resp_rdy_d;
            resp_q      <= resp_d;
        end
    end

    assign cmd_snt  = cmd_snt_q;
    assign resp_rdy = resp_rdy_q;
    assign resp     = resp_q;

endmodule

// File: tb/tb_remote_cmd_link.sv
// Directed bench for remote_cmd_link: TX frames and response bytes are checked against
// expectation queues filled when the stimulus is driven.
module tb_remote_cmd_link;
    import remote_cmd_link_pkg::*;

    localparam int BD = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_drv;
    logic        loop_en;
    logic        rx_line;
    logic        tx;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    int n_assert = 0;
    int n_fail   = 0;
    int n_resp   = 0;
    int n_resp_before;
    logic rdy_prev = 1'b0;

    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_resp_q[$];

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    remote_cmd_link #(
        .BAUD_DIV (BD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (rx_line),
        .TX       (tx),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .cmd_snt  (cmd_snt),
        .resp_rdy (resp_rdy),
        .resp     (resp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response scoreboard: each new rise of resp_rdy is matched against the oldest expected byte
    always @(negedge clk) begin
        if (resp_rdy === 1'b1 && rdy_prev !== 1'b1) begin
            n_resp++;
            n_assert++;
            assert (exp_resp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL resp_unexpected: observed %0h expected no response", resp);
            end
            if (exp_resp_q.size() > 0) check("resp_byte", {24'h0, resp}, {24'h0, exp_resp_q.pop_front()});
        end
        rdy_prev = resp_rdy;
    end

    initial begin
        #(200000);
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    // Issue a command and decode both TX frames at mid-bit; optionally re-pulse snd_cmd at one bit slot
    task automatic send_cmd(input logic [15:0] c, input int glitch_bit);
        logic [9:0] frame;
        logic [7:0] exp_b;
        int         wait_n;
        exp_tx_q.push_back(c[15:8]);
        exp_tx_q.push_back(c[7:0]);
        @(negedge clk);
        cmd     = c;
        snd_cmd = 1'b1;
        @(posedge clk);
        #1 snd_cmd = 1'b0;
        check("cmd_snt_clr", {31'h0, cmd_snt}, 32'h0);
        check("resp_rdy_clr", {31'h0, resp_rdy}, 32'h0);
        repeat (BD / 2) @(posedge clk);
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 10; b++) begin
                #1 frame[b] = tx;
                wait_n = (f == 1 && b == 9) ? (BD / 2 - 1) : BD;
                if (f * 10 + b == glitch_bit) begin
                    cmd     = ~c;
                    snd_cmd = 1'b1;
                    @(posedge clk);
                    #1 snd_cmd = 1'b0;
                    repeat (wait_n - 1) @(posedge clk);
                end else begin
                    repeat (wait_n) @(posedge clk);
                end
            end
            exp_b = exp_tx_q.pop_front();
            check(f == 0 ? "tx_frame_hi" : "tx_frame_lo", {22'h0, frame}, {22'h0, 1'b1, exp_b, 1'b0});
        end
        #1 check("cmd_snt_early", {31'h0, cmd_snt}, 32'h0);
        @(posedge clk);
        #1 check("cmd_snt_set", {31'h0, cmd_snt}, 32'h1);
        check("tx_idle_after", {31'h0, tx}, 32'h1);
    endtask

    // Drive one 8N1 byte on RX from the bench side
    task automatic drive_rx(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        exp_resp_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            if (i == 9) check("rx_rdy_not_early", {31'h0, resp_rdy}, 32'h0);
            repeat (BD) @(posedge clk);
            #1;
        end
        check("rx_rdy_set", {31'h0, resp_rdy}, 32'h1);
        check("rx_resp_val", {24'h0, resp}, {24'h0, b});
    endtask

    initial begin
        rst     = 1'b1;
        snd_cmd = 1'b0;
        cmd     = 16'h0000;
        rx_drv  = 1'b1;
        loop_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_cmd_snt", {31'h0, cmd_snt}, 32'h0);
        check("rst_resp_rdy", {31'h0, resp_rdy}, 32'h0);
        check("rst_resp", {24'h0, resp}, 32'h0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_tx", {31'h0, tx}, 32'h1);
        check("idle_cmd_snt", {31'h0, cmd_snt}, 32'h0);

        send_cmd(16'h7020, -1);

        drive_rx(ACK);
        repeat (3 * BD) @(posedge clk);
        #1;
        check("resp_rdy_hold", {31'h0, resp_rdy}, 32'h1);
        check("resp_hold", {24'h0, resp}, {24'h0, ACK});

        send_cmd(16'h5AC3, 12);
        check("resp_kept_after_snd", {24'h0, resp}, {24'h0, ACK});

        @(negedge clk) loop_en = 1'b1;
        n_resp_before = n_resp;
        exp_resp_q.push_back(CAL_GYRO[15:8]);
        exp_resp_q.push_back(CAL_GYRO[7:0]);
        send_cmd(CAL_GYRO, -1);
        repeat (2 * BD) @(posedge clk);
        #1;
        check("loop_resp_count", n_resp - n_resp_before, 32'd2);
        check("loop_resp_final", {24'h0, resp}, 32'h0);
        check("loop_resp_rdy", {31'h0, resp_rdy}, 32'h1);
        @(negedge clk) loop_en = 1'b0;

        @(negedge clk);
        cmd     = 16'h1200;
        snd_cmd = 1'b1;
        @(posedge clk);
        #1 snd_cmd = 1'b0;
        repeat (15 * BD) @(posedge clk);
        #1;
        check("tx_low_before_rst", {31'h0, tx}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx", {31'h0, tx}, 32'h1);
        check("midrst_cmd_snt", {31'h0, cmd_snt}, 32'h0);
        rst = 1'b0;
        repeat (6 * BD) @(posedge clk);
        #1;
        check("postrst_tx_idle", {31'h0, tx}, 32'h1);
        check("postrst_cmd_snt", {31'h0, cmd_snt}, 32'h0);

        send_cmd(16'h7020, -1);

        repeat (BD) @(posedge clk);
        #1;
        check("tx_queue_empty", exp_tx_q.size(), 32'd0);
        check("resp_queue_empty", exp_resp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
